// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: opcodes, functs,
// ALU control codes, mux select codes and FSM state encodings.
package mips_pkg;

  // Opcodes (Instr[31:26])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // R-type functs (Instr[5:0])
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  // ALUControl codes
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  // ALUSrcB selects
  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  // PCSrc selects
  localparam logic [1:0] PcAluResult = 2'b00;
  localparam logic [1:0] PcAluOut    = 2'b01;
  localparam logic [1:0] PcJump      = 2'b10;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiEx   = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11,
    StFault    = 4'd15
  } state_e;

endpackage

// File: rtl/alu_decoder.sv
// Combinational R-type funct decoder: ALU control code plus a legality flag.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o,
  output logic       valid_o
);

  // Map funct to ALU operation; unknown functs flag invalid and drive AND code
  always_comb begin
    alu_ctrl_o = AluAnd;
    valid_o    = 1'b1;
    unique case (funct_i)
      FnAdd:   alu_ctrl_o = AluAdd;
      FnSub:   alu_ctrl_o = AluSub;
      FnAnd:   alu_ctrl_o = AluAnd;
      FnOr:    alu_ctrl_o = AluOr;
      FnSlt:   alu_ctrl_o = AluSlt;
      default: valid_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory-ready handshake, bounded memory
// waits and a sticky fault state for illegal opcodes/functs and timeouts.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 5,
  parameter bit          EN_BNE       = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       pc_en,
  output logic       fault,
  output logic [3:0] state_dbg
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]       alu_ctrl;
  logic             funct_valid;
  logic             mem_state;
  logic             timeout;

  alu_decoder u_alu_decoder (
    .funct_i    (funct),
    .alu_ctrl_o (alu_ctrl),
    .valid_o    (funct_valid)
  );

  assign mem_state = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
  // Ready in the final wait cycle still wins over the timeout
  assign timeout   = mem_state && !mem_ready && (wait_cnt_q == CNT_W'(WAIT_TIMEOUT - 1));

  // State and wait counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StFetch;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic and wait counter update
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready)    state_d = StDecode;
        else if (timeout) state_d = StFault;
      end
      StDecode: begin
        unique case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpBne:      state_d = EN_BNE ? StBranch : StFault;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StFault;
        endcase
      end
      StMemAdr:  state_d = (opcode == OpSw) ? StMemWrite : StMemRead;
      StMemRead: begin
        if (mem_ready)    state_d = StMemWb;
        else if (timeout) state_d = StFault;
      end
      StMemWb:   state_d = StFetch;
      StMemWrite: begin
        if (mem_ready)    state_d = StFetch;
        else if (timeout) state_d = StFault;
      end
      StExecute: state_d = funct_valid ? StAluWb : StFault;
      StAluWb:   state_d = StFetch;
      StBranch:  state_d = StFetch;
      StAddiEx:  state_d = StAddiWb;
      StAddiWb:  state_d = StFetch;
      StJump:    state_d = StFetch;
      StFault:   state_d = StFault;
      default:   state_d = StFault;
    endcase

    wait_cnt_d = '0;
    if (mem_state && !mem_ready && (state_d == state_q)) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  // Moore output decode; IRWrite/pc_en additionally qualified by ready/zero
  always_comb begin
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SrcBReg;
    ALUControl = AluAnd;
    PCSrc      = PcAluResult;
    pc_en      = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req    = 1'b1;
        ALUSrcB    = SrcBFour;
        ALUControl = AluAdd;
        IRWrite    = mem_ready;
        pc_en      = mem_ready;
      end
      StDecode: begin
        ALUSrcB    = SrcBImmSh;
        ALUControl = AluAdd;
      end
      StMemAdr, StAddiEx: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SrcBImm;
        ALUControl = AluAdd;
      end
      StMemRead: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      StMemWrite: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StExecute: begin
        ALUSrcA    = 1'b1;
        ALUControl = alu_ctrl;
      end
      StAluWb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      StBranch: begin
        ALUSrcA    = 1'b1;
        ALUControl = AluSub;
        PCSrc      = PcAluOut;
        pc_en      = (opcode == OpBne) ? !zero : zero;
      end
      StAddiWb: RegWrite = 1'b1;
      StJump: begin
        PCSrc = PcJump;
        pc_en = 1'b1;
      end
      default: ;
    endcase
    // Suppress every write enable while reset is held
    if (!reset) begin
      IRWrite  = 1'b0;
      pc_en    = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

  assign fault     = (state_q == StFault);
  assign state_dbg = state_q;

endmodule
